// File: rtl/rc4_phase_sched.sv
// RC4 pass scheduler: sequences init, shuffle and PRGA phase FSMs and
// grants the single-port S memory to whichever phase is running.
// Ports: clk, rst (sync, active-high), go, abort -> busy, done, error;
//   per phase x in {init, shuf, prga}: x_start out; x_fin, x_addr,
//   x_wdata, x_wren in; mem_addr, mem_wdata, mem_wren out to S RAM.
// Optional watchdog: define RC4_SCHED_WDOG_EN (WDOG_CYCLES per phase).
module rc4_phase_sched #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WDOG_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              init_start,
  input  logic              init_fin,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  input  logic              init_wren,
  output logic              shuf_start,
  input  logic              shuf_fin,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [DATA_W-1:0] shuf_wdata,
  input  logic              shuf_wren,
  output logic              prga_start,
  input  logic              prga_fin,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ST_INIT  = 4'd1,
    RUN_INIT = 4'd2,
    ST_SHUF  = 4'd3,
    RUN_SHUF = 4'd4,
    ST_PRGA  = 4'd5,
    RUN_PRGA = 4'd6,
    DONE     = 4'd7
`ifdef RC4_SCHED_WDOG_EN
    , ERROR  = 4'd8
`endif
  } state_t;

  state_t state;
  state_t nxt;
  logic   wdog_hit;

`ifdef RC4_SCHED_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES) + 1;
  localparam logic [CW-1:0] WD_LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          in_run;

  assign in_run   = (state == RUN_INIT) || (state == RUN_SHUF) ||
                    (state == RUN_PRGA);
  assign wdog_hit = in_run && (cnt == WD_LAST);

  // Cleared while in ST_x so each RUN state starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (in_run) cnt <= cnt + 1'b1;
    else             cnt <= '0;
  end
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES > 0);
  assign wdog_hit    = 1'b0;
`endif

  // Fin outranks the watchdog; abort outranks both.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (go) nxt = ST_INIT;
      ST_INIT:  nxt = RUN_INIT;
      RUN_INIT: if (init_fin) nxt = ST_SHUF;
`ifdef RC4_SCHED_WDOG_EN
                else if (wdog_hit) nxt = ERROR;
`endif
      ST_SHUF:  nxt = RUN_SHUF;
      RUN_SHUF: if (shuf_fin) nxt = ST_PRGA;
`ifdef RC4_SCHED_WDOG_EN
                else if (wdog_hit) nxt = ERROR;
`endif
      ST_PRGA:  nxt = RUN_PRGA;
      RUN_PRGA: if (prga_fin) nxt = DONE;
`ifdef RC4_SCHED_WDOG_EN
                else if (wdog_hit) nxt = ERROR;
      ERROR:    nxt = ERROR;
`endif
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end

  // Outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      init_start <= 1'b0;
      shuf_start <= 1'b0;
      prga_start <= 1'b0;
    end else begin
      state      <= nxt;
      busy       <= (nxt != IDLE);
      done       <= (nxt == DONE);
`ifdef RC4_SCHED_WDOG_EN
      error      <= (nxt == ERROR);
`else
      error      <= 1'b0;
`endif
      init_start <= (nxt == ST_INIT);
      shuf_start <= (nxt == ST_SHUF);
      prga_start <= (nxt == ST_PRGA);
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      RUN_INIT: begin
        mem_addr  = init_addr;
        mem_wdata = init_wdata;
        mem_wren  = init_wren;
      end
      RUN_SHUF: begin
        mem_addr  = shuf_addr;
        mem_wdata = shuf_wdata;
        mem_wren  = shuf_wren;
      end
      RUN_PRGA: begin
        mem_addr  = prga_addr;
        mem_wdata = prga_wdata;
        mem_wren  = prga_wren;
      end
      default: ;
    endcase
    // A write must not land in the cycle the pass is being torn down.
    if (abort) mem_wren = 1'b0;
  end

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Directed bench for rc4_phase_sched.
// Hand-computed expectations, immediate assertions at each check.
module tb_rc4_phase_sched;

  logic       clk = 1'b0;
  logic       rst, go, abort;
  logic       busy, done, error;
  logic       init_start, shuf_start, prga_start;
  logic       init_fin, shuf_fin, prga_fin;
  logic [7:0] init_addr, shuf_addr, prga_addr;
  logic [7:0] init_wdata, shuf_wdata, prga_wdata;
  logic       init_wren, shuf_wren, prga_wren;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_wren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc4_phase_sched #(.ADDR_W(8), .DATA_W(8), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .init_start(init_start), .init_fin(init_fin),
    .init_addr(init_addr), .init_wdata(init_wdata),
    .init_wren(init_wren),
    .shuf_start(shuf_start), .shuf_fin(shuf_fin),
    .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata),
    .shuf_wren(shuf_wren),
    .prga_start(prga_start), .prga_fin(prga_fin),
    .prga_addr(prga_addr), .prga_wdata(prga_wdata),
    .prga_wren(prga_wren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren)
  );

  logic [2:0] starts;
  assign starts = {prga_start, shuf_start, init_start};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_flags"}, {29'd0, done, error, 1'b0}, 32'd0);
    chk({tag, "_starts"}, 32'(starts), 32'd0);
    chk({tag, "_mem"}, {15'd0, mem_wren, mem_addr, mem_wdata}, 32'd0);
  endtask

  task automatic set_fin(input int p, input logic v);
    case (p)
      0: init_fin = v;
      1: shuf_fin = v;
      default: prga_fin = v;
    endcase
  endtask

  // Called with the DUT in ST_x; phase returns fin 3 cycles after start.
  task automatic phase(input int p);
    logic [7:0] a;
    a = 8'(8'h11 * (p + 1));
    chk($sformatf("st%0d_start", p), 32'(starts), 32'(1 << p));
    chk($sformatf("st%0d_wren", p), {mem_wren, mem_addr}, 32'd0);
    step();
    chk($sformatf("run%0d_start", p), 32'(starts), 32'd0);
    chk($sformatf("run%0d_mem", p), {mem_wren, mem_addr, mem_wdata},
        {15'd0, 1'b1, a, 8'(8'hA1 + p)});
    step();
    step();
    set_fin(p, 1'b1);
    step();
    set_fin(p, 1'b0);
  endtask

  int n;

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0;
    init_fin = 1'b0; shuf_fin = 1'b0; prga_fin = 1'b0;
    init_addr = 8'h11; shuf_addr = 8'h22; prga_addr = 8'h33;
    init_wdata = 8'hA1; shuf_wdata = 8'hA2; prga_wdata = 8'hA3;
    init_wren = 1'b1; shuf_wren = 1'b1; prga_wren = 1'b1;
    step(); step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("idle");

    // Full pass with mux isolation.
    go = 1'b1;
    step();
    go = 1'b0;
    phase(0);
    phase(1);
    phase(2);
    chk("pass_done", {busy, done, mem_wren, mem_addr}, {3'b110, 8'h00});
    step();
    chk_idle("pass_end");

    // Stray strobes during RUN_INIT.
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    prga_fin = 1'b1; shuf_fin = 1'b1;
    step();
    prga_fin = 1'b0; shuf_fin = 1'b0;
    chk("stray_starts", 32'(starts), 32'd0);
    chk("stray_addr", 32'(mem_addr), 32'h11);
    step();
    chk("stray_hold", {starts, mem_addr}, {3'd0, 8'h11});
    init_fin = 1'b1;
    step();
    init_fin = 1'b0;
    chk("stray_shuf", 32'(starts), 32'd2);

    // Abort together with shuf_fin in RUN_SHUF.
    step();
    abort = 1'b1; shuf_fin = 1'b1;
    #1;
    chk("abort_wren", 32'(mem_wren), 32'd0);
    step();
    abort = 1'b0; shuf_fin = 1'b0;
    chk_idle("abort");
    step();
    step();
    chk("abort_after", {busy, done, starts}, 32'd0);

    // go during RUN_PRGA is ignored.
    go = 1'b1;
    step();
    go = 1'b0;
    phase(0);
    phase(1);
    chk("gobusy_st", 32'(starts), 32'd4);
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    chk("gobusy_run", {busy, starts, mem_addr}, {1'b1, 3'd0, 8'h33});
    prga_fin = 1'b1;
    step();
    prga_fin = 1'b0;
    chk("gobusy_done", 32'(done), 32'd1);
    step();
    chk_idle("gobusy_idle");
    step();
    chk_idle("gobusy_noreq");

    // rst in RUN_SHUF of a later pass.
    go = 1'b1;
    step();
    go = 1'b0;
    phase(0);
    step();
    chk("rst_pre", 32'(mem_addr), 32'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst");

    // Ideal phases (fins held high): go to done in 7 cycles.
    init_fin = 1'b1; shuf_fin = 1'b1; prga_fin = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd7);
    // go held through DONE restarts from IDLE next cycle.
    go = 1'b1;
    step();
    chk("regos_idle", {busy, starts}, 32'd0);
    step();
    go = 1'b0;
    chk("regos_start", {busy, starts}, {28'd0, 1'b1, 3'd1});
    abort = 1'b1;
    step();
    abort = 1'b0;
    init_fin = 1'b0; shuf_fin = 1'b0; prga_fin = 1'b0;
    chk_idle("regos_abort");

`ifdef RC4_SCHED_WDOG_EN
    // Init phase never returns fin.
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    for (int i = 1; i < 16; i++) step();
    chk("wd_pre", {error, mem_wren}, 32'd1);
    step();
    chk("wd_err", {error, busy, mem_wren, starts}, {26'd0, 6'b110000});
    step();
    chk("wd_hold", {error, busy}, 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("wd_abort");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
